// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX operand forwarding selects and load-use stall control
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic                  fwd_a_s0,
    output logic                  fwd_a_s1,
    output logic                  fwd_b_s0,
    output logic                  fwd_b_s1,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_regwrite_q, ex_regwrite_d;
    logic                  ex_memread_q, ex_memread_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic                  ex_uses_rs1_q, ex_uses_rs1_d;
    logic                  ex_uses_rs2_q, ex_uses_rs2_d;

    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_regwrite_q, mem_regwrite_d;
    logic                  mem_memread_q, mem_memread_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic                  wb_memread_q, wb_memread_d;

    logic ex_is_load_dst;
    logic mem_writes, wb_writes;

    // Load in EX whose nonzero destination is read by the ID instruction.
    always_comb begin
        ex_is_load_dst = ex_valid_q && ex_memread_q && ex_regwrite_q &&
                         (ex_rd_q != '0);
        stall = id_valid && ex_is_load_dst &&
                ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd_q)));
    end

    always_comb begin
        mem_writes = mem_valid_q && mem_regwrite_q && (mem_rd_q != '0);
        wb_writes  = wb_valid_q && wb_regwrite_q && (wb_rd_q != '0);
        fwd_a_s0 = ex_valid_q && ex_uses_rs1_q && mem_writes && (mem_rd_q == ex_rs1_q);
        fwd_a_s1 = ex_valid_q && ex_uses_rs1_q && wb_writes && (wb_rd_q == ex_rs1_q) &&
                   !fwd_a_s0;
        fwd_b_s0 = ex_valid_q && ex_uses_rs2_q && mem_writes && (mem_rd_q == ex_rs2_q);
        fwd_b_s1 = ex_valid_q && ex_uses_rs2_q && wb_writes && (wb_rd_q == ex_rs2_q) &&
                   !fwd_b_s0;
    end

    always_comb begin
        ex_valid_d    = id_valid && !stall && !flush;
        ex_rd_d       = id_rd;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_uses_rs1_d = id_uses_rs1;
        ex_uses_rs2_d = id_uses_rs2;

        mem_valid_d    = ex_valid_q;
        mem_rd_d       = ex_rd_q;
        mem_regwrite_d = ex_regwrite_q;
        mem_memread_d  = ex_memread_q;

        wb_valid_d    = mem_valid_q;
        wb_rd_d       = mem_rd_q;
        wb_regwrite_d = mem_regwrite_q;
        wb_memread_d  = mem_memread_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_uses_rs1_q  <= 1'b0;
            ex_uses_rs2_q  <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_memread_q   <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_uses_rs1_q  <= ex_uses_rs1_d;
            ex_uses_rs2_q  <= ex_uses_rs2_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_memread_q  <= mem_memread_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_memread_q   <= wb_memread_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed and randomized check of hazard_forward_ctrl against a pipeline model
module tb_hazard_forward_ctrl;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs1 = '0;
    logic [RW-1:0] id_rs2 = '0;
    logic          id_uses_rs1 = 1'b0;
    logic          id_uses_rs2 = 1'b0;
    logic [RW-1:0] id_rd = '0;
    logic          id_regwrite = 1'b0;
    logic          id_memread = 1'b0;
    logic          flush = 1'b0;
    logic          fwd_a_s0, fwd_a_s1, fwd_b_s0, fwd_b_s1, stall;
    logic [CW-1:0] stall_cnt;

    hazard_forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush),
        .fwd_a_s0(fwd_a_s0), .fwd_a_s1(fwd_a_s1),
        .fwd_b_s0(fwd_b_s0), .fwd_b_s1(fwd_b_s1),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } instr_t;

    // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
    instr_t pipe [3];
    int     model_cnt;
    int     n_checks = 0;
    int     n_pass = 0;
    int     obs_fa0, obs_fa1, obs_fb0, obs_fb1, obs_stall;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b.v = 0; b.rd = 0; b.rw = 0; b.mr = 0; b.rs1 = 0; b.rs2 = 0; b.u1 = 0; b.u2 = 0;
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = bubble();
        model_cnt = 0;
    endtask

    // 0 = register file, 1 = youngest older writer is in MEM, 2 = in WB
    function automatic int fwd_source(input int rs, input bit uses);
        if (!pipe[0].v || !uses || rs == 0) return 0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].v && pipe[k].rw && pipe[k].rd == rs) return k;
        return 0;
    endfunction

    function automatic bit load_use(input instr_t id);
        instr_t ex;
        ex = pipe[0];
        if (!id.v || !ex.v || !ex.mr || !ex.rw || ex.rd == 0) return 0;
        return (id.u1 && id.rs1 == ex.rd) || (id.u2 && id.rs2 == ex.rd);
    endfunction

    task automatic step(input instr_t id, input bit fl);
        int sa, sb;
        bit es;
        @(negedge clk);
        id_valid = id.v; id_rs1 = RW'(id.rs1); id_rs2 = RW'(id.rs2);
        id_uses_rs1 = id.u1; id_uses_rs2 = id.u2; id_rd = RW'(id.rd);
        id_regwrite = id.rw; id_memread = id.mr; flush = fl;
        #1;
        sa = fwd_source(pipe[0].rs1, pipe[0].u1);
        sb = fwd_source(pipe[0].rs2, pipe[0].u2);
        es = load_use(id);
        obs_fa0 = int'(fwd_a_s0); obs_fa1 = int'(fwd_a_s1);
        obs_fb0 = int'(fwd_b_s0); obs_fb1 = int'(fwd_b_s1);
        obs_stall = int'(stall);
        check("fwd_a_s0", obs_fa0, int'(sa == 1));
        check("fwd_a_s1", obs_fa1, int'(sa == 2));
        check("fwd_b_s0", obs_fb0, int'(sb == 1));
        check("fwd_b_s1", obs_fb1, int'(sb == 2));
        check("stall", obs_stall, int'(es));
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", int'(stall_cnt), model_cnt);
`else
        check("stall_cnt", int'(stall_cnt), 0);
`endif
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (es || fl) ? bubble() : id;
        if (es && model_cnt < (1 << CW) - 1) model_cnt++;
    endtask

    function automatic instr_t mk(input int rd, input bit rw, input bit mr,
                                  input int rs1, input bit u1, input int rs2, input bit u2);
        instr_t i;
        i.v = 1; i.rd = rd; i.rw = rw; i.mr = mr;
        i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        return i;
    endfunction

    instr_t nop, cur;
    bit     fl_r;

    initial begin
        nop = bubble();
        model_reset();
        #1;
        check("reset_fwd_a_s0", int'(fwd_a_s0), 0);
        check("reset_stall", int'(stall), 0);
        check("reset_stall_cnt", int'(stall_cnt), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // EX/MEM forward, then gone one cycle later
        step(mk(5, 1, 0, 1, 1, 2, 1), 0);
        step(mk(6, 1, 0, 5, 1, 0, 0), 0);
        step(nop, 0);
        check("exmem_a_s0", obs_fa0, 1);
        check("exmem_a_s1", obs_fa1, 0);
        step(nop, 0);
        check("exmem_after_s0", obs_fa0, 0);

        // MEM/WB forward at distance 2
        step(mk(7, 1, 0, 0, 0, 0, 0), 0);
        step(mk(8, 1, 0, 1, 1, 1, 1), 0);
        step(mk(9, 1, 0, 0, 0, 7, 1), 0);
        step(nop, 0);
        check("memwb_b_s1", obs_fb1, 1);
        check("memwb_b_s0", obs_fb0, 0);

        // MEM has priority over WB
        step(mk(7, 1, 0, 0, 0, 0, 0), 0);
        step(mk(7, 1, 0, 0, 0, 0, 0), 0);
        step(mk(9, 1, 0, 0, 0, 7, 1), 0);
        step(nop, 0);
        check("prio_b_s0", obs_fb0, 1);
        check("prio_b_s1", obs_fb1, 0);

        // x0 load never stalls; unused operand never stalls
        step(mk(0, 1, 1, 0, 0, 0, 0), 0);
        step(mk(4, 1, 0, 0, 1, 0, 0), 0);
        check("x0_no_stall", obs_stall, 0);
        step(mk(3, 1, 1, 0, 0, 0, 0), 0);
        step(mk(4, 1, 0, 3, 0, 0, 0), 0);
        check("lui_no_stall", obs_stall, 0);

        // flush kills the dependent instruction leaving ID
        step(mk(4, 1, 0, 0, 0, 0, 0), 0);
        step(mk(10, 1, 0, 4, 1, 0, 0), 1);
        step(nop, 0);
        check("flush_no_fwd", obs_fa0, 0);

        // flush together with stall: single bubble
        step(mk(6, 1, 1, 0, 0, 0, 0), 0);
        step(mk(11, 1, 0, 6, 1, 0, 0), 1);
        check("flush_stall", obs_stall, 1);
        step(nop, 0);
        step(nop, 0);

        // randomized traffic; ID held while stalled
        cur = nop;
        fl_r = 0;
        for (int n = 0; n < 400; n++) begin
            if (n == 0 || obs_stall == 0 || fl_r) begin
                cur.v = ($urandom_range(7) != 0);
                cur.rd = $urandom_range(7); cur.rw = $urandom_range(1);
                cur.mr = ($urandom_range(2) == 0);
                cur.rs1 = $urandom_range(7); cur.u1 = ($urandom_range(3) != 0);
                cur.rs2 = $urandom_range(7); cur.u2 = ($urandom_range(3) != 0);
            end
            fl_r = ($urandom_range(9) == 0);
            step(cur, fl_r);
        end

        // asynchronous reset mid-stream with instructions in flight
        step(mk(12, 1, 0, 0, 0, 0, 0), 0);
        step(mk(13, 1, 1, 12, 1, 12, 1), 0);
        step(mk(14, 1, 0, 13, 1, 0, 0), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_fwd_a_s0", int'(fwd_a_s0), 0);
        check("mid_reset_fwd_a_s1", int'(fwd_a_s1), 0);
        check("mid_reset_fwd_b_s0", int'(fwd_b_s0), 0);
        check("mid_reset_fwd_b_s1", int'(fwd_b_s1), 0);
        check("mid_reset_stall", int'(stall), 0);
        check("mid_reset_stall_cnt", int'(stall_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // load-use: exactly one stall cycle, then forward from WB
        step(mk(9, 1, 1, 0, 0, 0, 0), 0);
        step(mk(15, 1, 0, 9, 1, 0, 0), 0);
        check("ldu_stall", obs_stall, 1);
        step(mk(15, 1, 0, 9, 1, 0, 0), 0);
        check("ldu_stall_once", obs_stall, 0);
        step(nop, 0);
        check("ldu_fwd_a_s1", obs_fa1, 1);
        check("ldu_fwd_a_s0", obs_fa0, 0);
`ifdef HAZARD_PERF_CNT_EN
        check("ldu_stall_cnt", int'(stall_cnt), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
